// File: rtl/banked_mem_responder_pkg.sv
// Shared constants, request decode type and helper for the banked memory responder.
package banked_mem_responder_pkg;

    localparam int BANK_SEL_LSB  = 1;
    localparam int NUM_BANKS     = 4;
    localparam int BANK_W        = 2;
    localparam int IDX_LSB       = BANK_SEL_LSB + BANK_W;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_IDX_W     = 8;
    localparam int DEF_BANK_BUSY = 4;
    localparam int DEF_RD_LAT    = 2;

    // Decoded view of the incoming beat.
    typedef struct packed {
        logic              rd;
        logic              wr;
        logic              req;
        logic              mal;
        logic [BANK_W-1:0] bank;
    } req_dec_t;

    // Both strobes at once, or an odd byte address, is not a legal word beat.
    function automatic logic is_malformed(input logic rd, input logic wr, input logic a0);
        return (rd & wr) | ((rd | wr) & a0);
    endfunction

endpackage

// File: rtl/banked_mem_responder_mem_bank.sv
// One memory bank: word storage, occupancy counter, write port and registered read sample.
module mem_bank
    import banked_mem_responder_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int BANK_BUSY = DEF_BANK_BUSY
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_acc_rd,
    input  logic              i_acc_wr,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int CNT_W = $clog2(BANK_BUSY);
    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata;

    // Occupancy: reload on any accept, then count down to idle.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_acc_rd | i_acc_wr)
            r_cnt <= CNT_W'(BANK_BUSY - 1);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    // Storage: cleared on reset, written at the end of the accept cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (i_acc_wr) begin
            r_mem[i_idx] <= i_wdata;
        end
    end

    // Read sample: first stage of the read latency, held until the bank reads again.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_rdata <= '0;
        else if (i_acc_rd)
            r_rdata <= r_mem[i_idx];
    end

    assign o_busy  = (r_cnt != '0);
    assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved memory responder: bank decode, stall/err, read pipeline, output mux.
module banked_mem_responder
    import banked_mem_responder_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int BANK_BUSY = DEF_BANK_BUSY,
    parameter int RD_LAT    = DEF_RD_LAT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [DATA_W-1:0]    i_data_in,
    input  logic                 i_rd,
    input  logic                 i_wr,
    output logic [DATA_W-1:0]    o_data_out,
    output logic                 o_rd_valid,
    output logic                 o_stall,
    output logic [NUM_BANKS-1:0] o_busy,
    output logic                 o_err
);

    req_dec_t                           w_dec;
    logic [IDX_W-1:0]                   w_idx;
    logic                               w_acc;
    logic                               w_acc_rd;
    logic                               w_acc_wr;
    logic [NUM_BANKS-1:0]               w_busy;
    logic [NUM_BANKS-1:0][DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]                  w_out_dat;
    logic                               w_unused_addr;

    logic [RD_LAT:1]                    r_vld_pipe;
    logic [BANK_W-1:0]                  r_sel1;
    logic                               r_err;

    assign w_dec.rd   = i_rd;
    assign w_dec.wr   = i_wr;
    assign w_dec.req  = i_rd | i_wr;
    assign w_dec.mal  = is_malformed(i_rd, i_wr, i_addr[0]);
    assign w_dec.bank = i_addr[BANK_SEL_LSB +: BANK_W];
    assign w_idx      = i_addr[IDX_LSB +: IDX_W];
    assign w_unused_addr = ^i_addr[ADDR_W-1:IDX_LSB+IDX_W];

    assign w_acc    = w_dec.req & ~w_dec.mal & ~w_busy[w_dec.bank] & ~i_rst;
    assign w_acc_rd = w_acc & w_dec.rd;
    assign w_acc_wr = w_acc & w_dec.wr;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .DATA_W    (DATA_W),
            .IDX_W     (IDX_W),
            .BANK_BUSY (BANK_BUSY)
        ) u_bank (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_acc_rd (w_acc_rd && (w_dec.bank == BANK_W'(g))),
            .i_acc_wr (w_acc_wr && (w_dec.bank == BANK_W'(g))),
            .i_idx    (w_idx),
            .i_wdata  (i_data_in),
            .o_busy   (w_busy[g]),
            .o_rdata  (w_rdata[g])
        );
    end

    // Read valid shift register; stage 1 lines up with the bank's read sample.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= w_acc_rd;
            for (int k = 2; k <= RD_LAT; k++)
                r_vld_pipe[k] <= r_vld_pipe[k-1];
        end
    end

    // Remember which bank holds the stage-1 read sample.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_sel1 <= '0;
        else if (w_acc_rd)
            r_sel1 <= w_dec.bank;
    end

    if (RD_LAT == 1) begin : g_lat1
        assign w_out_dat = w_rdata[r_sel1];
    end else begin : g_pipe
        logic [RD_LAT:2][DATA_W-1:0] r_dat;
        // Remaining read latency stages after the bank sample.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_dat <= '0;
            end else begin
                r_dat[2] <= w_rdata[r_sel1];
                for (int k = 3; k <= RD_LAT; k++)
                    r_dat[k] <= r_dat[k-1];
            end
        end
        assign w_out_dat = r_dat[RD_LAT];
    end

    // Malformed beats flag err for exactly the following cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_err <= 1'b0;
        else
            r_err <= w_dec.mal;
    end

    assign o_rd_valid = r_vld_pipe[RD_LAT];
    assign o_data_out = r_vld_pipe[RD_LAT] ? w_out_dat : '0;
    assign o_stall    = w_dec.req & ~w_dec.mal & w_busy[w_dec.bank];
    assign o_busy     = w_busy;
    assign o_err      = r_err;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Bench for banked_mem_responder: cycle model with bank timers, memory array and read-due map.
module tb_banked_mem_responder;

    localparam int BB = 4;
    localparam int RL = 2;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_addr = '0;
    logic [15:0] i_data_in = '0;
    logic        i_rd = 1'b0;
    logic        i_wr = 1'b0;
    logic [15:0] o_data_out;
    logic        o_rd_valid;
    logic        o_stall;
    logic [3:0]  o_busy;
    logic        o_err;

    banked_mem_responder dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_addr     (i_addr),
        .i_data_in  (i_data_in),
        .i_rd       (i_rd),
        .i_wr       (i_wr),
        .o_data_out (o_data_out),
        .o_rd_valid (o_rd_valid),
        .o_stall    (o_stall),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    bit          m_ok = 0;
    int          free_at [4];
    logic [15:0] mem [4][256];
    logic [15:0] due [int];
    int          err_due = -1;

    int nvec = 0;
    int nfail = 0;
    logic [15:0] rv_log [$];
    int          rv_cyc [$];

    function automatic int bank_of(input logic [15:0] a);
        return int'((a >> 1) & 16'd3);
    endfunction

    function automatic int idx_of(input logic [15:0] a);
        return int'((a >> 3) & 16'd255);
    endfunction

    function automatic bit m_mal();
        return (i_rd && i_wr) || ((i_rd || i_wr) && i_addr[0]);
    endfunction

    function automatic bit m_stall();
        return (i_rd || i_wr) && !m_mal() && (cyc < free_at[bank_of(i_addr)]);
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < 4; b++) begin
                free_at[b] = 0;
                for (int j = 0; j < 256; j++) mem[b][j] = '0;
            end
            foreach (due[k]) if (k > cyc) due.delete(k);
            err_due = -1;
            m_ok = 1;
        end else if (m_ok) begin
            if (m_mal()) begin
                err_due = cyc + 1;
            end else if ((i_rd || i_wr) && !(cyc < free_at[bank_of(i_addr)])) begin
                free_at[bank_of(i_addr)] = cyc + BB;
                if (i_wr) mem[bank_of(i_addr)][idx_of(i_addr)] = i_data_in;
                else      due[cyc + RL] = mem[bank_of(i_addr)][idx_of(i_addr)];
            end
        end
        cyc++;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge i_clk) begin
        if (m_ok) begin
            logic [3:0]  eb;
            logic        ev, es, ee;
            logic [15:0] ed;
            for (int b = 0; b < 4; b++) eb[b] = (cyc < free_at[b]);
            ev = due.exists(cyc);
            ed = ev ? due[cyc] : 16'h0;
            es = m_stall();
            ee = (err_due == cyc);
            nvec++;
            if (o_busy !== eb || o_rd_valid !== ev || o_data_out !== ed ||
                o_stall !== es || o_err !== ee) begin
                nfail++;
                $display("FAIL cycle %0d: busy %b/%b rd_valid %b/%b data %h/%h stall %b/%b err %b/%b (got/want)",
                         cyc, o_busy, eb, o_rd_valid, ev, o_data_out, ed, o_stall, es, o_err, ee);
            end
            if (o_rd_valid === 1'b1) begin
                rv_log.push_back(o_data_out);
                rv_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Present a beat and hold it until the model says it is taken; returns stall cycles.
    task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, output int w);
        i_rd = rd; i_wr = wr; i_addr = a; i_data_in = d;
        w = 0;
        forever begin
            @(negedge i_clk);
            if (!m_stall()) break;
            w++;
            if (w > 20) begin
                nfail++;
                $display("FAIL issue timeout: addr %h waited %0d cycles, want <= %0d", a, w, BB - 1);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        i_rd = 1'b0; i_wr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, limit 300000 want finish");
        $fatal(1);
    end

    initial begin
        int w, wsum;
        logic [15:0] a;
        idle(0);
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("reset busy", o_busy, 4'h0);
        chk("reset rd_valid", o_rd_valid, 1'b0);
        chk("reset data_out", o_data_out, 16'h0);
        chk("reset err", o_err, 1'b0);
        idle(1);

        // 1: write then read back once bank 0 is free
        issue(0, 1, 16'h0010, 16'hBEEF, w);
        chk("t1 write stall", w, 0);
        idle(3);
        issue(1, 0, 16'h0010, 16'h0, w);
        chk("t1 read stall", w, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("t1 rd_valid", o_rd_valid, 1'b1);
        chk("t1 data", o_data_out, 16'hBEEF);
        idle(1);

        // 2: four banks back to back
        idle(3);
        wsum = 0;
        issue(0, 1, 16'h0000, 16'h1111, w); wsum += w;
        issue(0, 1, 16'h0002, 16'h2222, w); wsum += w;
        issue(0, 1, 16'h0004, 16'h3333, w); wsum += w;
        issue(0, 1, 16'h0006, 16'h4444, w); wsum += w;
        rv_log.delete(); rv_cyc.delete();
        issue(1, 0, 16'h0000, 16'h0, w); wsum += w;
        issue(1, 0, 16'h0002, 16'h0, w); wsum += w;
        issue(1, 0, 16'h0004, 16'h0, w); wsum += w;
        issue(1, 0, 16'h0006, 16'h0, w); wsum += w;
        idle(4);
        chk("t2 stalls", wsum, 0);
        chk("t2 count", rv_log.size(), 4);
        if (rv_log.size() == 4) begin
            chk("t2 d0", rv_log[0], 16'h1111);
            chk("t2 d1", rv_log[1], 16'h2222);
            chk("t2 d2", rv_log[2], 16'h3333);
            chk("t2 d3", rv_log[3], 16'h4444);
            chk("t2 back-to-back", rv_cyc[3] - rv_cyc[0], 3);
        end

        // 3: same-bank conflict stalls three cycles
        idle(4);
        issue(0, 1, 16'h0000, 16'hAAAA, w);
        issue(1, 0, 16'h0008, 16'h0, w);
        chk("t3 stall cycles", w, 3);

        // 4: malformed beats
        idle(4);
        issue(1, 1, 16'h0010, 16'h1234, w);
        @(negedge i_clk);
        chk("t4 err rd&wr", o_err, 1'b1);
        chk("t4 busy rd&wr", o_busy, 4'h0);
        idle(1);
        issue(0, 1, 16'h0003, 16'h5555, w);
        @(negedge i_clk);
        chk("t4 err odd", o_err, 1'b1);
        chk("t4 stall odd", o_stall, 1'b0);
        idle(1);
        rv_log.delete(); rv_cyc.delete();
        issue(1, 0, 16'h0010, 16'h0, w);
        issue(1, 0, 16'h0002, 16'h0, w);
        idle(4);
        chk("t4 count", rv_log.size(), 2);
        if (rv_log.size() == 2) begin
            chk("t4 readback 0010", rv_log[0], 16'hBEEF);
            chk("t4 readback 0002", rv_log[1], 16'h2222);
        end

        // 5: reset drops an in-flight read and clears storage
        issue(0, 1, 16'h0012, 16'h9999, w);
        idle(4);
        issue(1, 0, 16'h0020, 16'h0, w);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("t5 rd_valid dropped", o_rd_valid, 1'b0);
        chk("t5 busy", o_busy, 4'h0);
        chk("t5 data_out", o_data_out, 16'h0);
        idle(1);
        rv_log.delete(); rv_cyc.delete();
        issue(1, 0, 16'h0012, 16'h0, w);
        idle(4);
        chk("t5 count", rv_log.size(), 1);
        if (rv_log.size() == 1) chk("t5 cleared", rv_log[0], 16'h0);

        // 6: random legal traffic
        for (int n = 0; n < 300; n++) begin
            a = 16'(($urandom_range(0, 7) << 3) | ($urandom_range(0, 3) << 1));
            if ($urandom_range(0, 1) == 1) issue(1, 0, a, 16'h0, w);
            else                           issue(0, 1, a, 16'($urandom), w);
            chk("t6 wait bound", (w <= BB - 1), 1);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
